knn_vote: RTL and testbench
===========================

Name: knn_vote

Overview:
- Downstream stage of the knn solver array. Once the solvers have finished, it reads out each solver's ranked neighbour list and produces one classification per solver.
- For every solver it drives SOLVER_SEL and SEL to fetch the HW_K neighbour labels, majority-votes them, and emits one result word through a valid/ready handshake.
- It sits between the knn block and the peripheral register/CPU interface.

Parameters:
- HW_K, 10, neighbours per solver (ranks 0..HW_K-1, rank 0 nearest).
- N_SOLVERS, 10, number of solvers to scan per run.
- N_CLASSES, 16, number of valid labels (0..N_CLASSES-1).
- LABEL_W, 16, width of the label word on data_in.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan of all solvers.
- sel  out  16  neighbour rank select to knn (SEL).
- solver_sel  out  16  solver select to knn (SOLVER_SEL).
- data_in  in  LABEL_W  label of neighbour (solver_sel, sel) from knn DATA_OUT; combinational on the selects.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_label  out  LABEL_W  winning label.
- res_votes  out  16  vote count of the winner.
- res_solver  out  16  solver index the result belongs to.
- done  out  1  one-cycle pulse after the last solver's result is accepted.
- err  out  1  sticky flag: an out-of-range label was seen; cleared on start.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: sel, solver_sel, busy, res_*, done, err.
  - All vote counters are cleared.
  - Reset applied mid-scan aborts immediately; no result or done is produced.
- Vote storage: N_CLASSES counters of width clog2(HW_K+1), plus best_label and best_count registers.
- State IDLE:
  - start==1 → CLEAR, with solver_sel=0 and err=0.
  - start is ignored in every other state.
- State CLEAR (1 cycle):
  - All counters, best_count and best_label go to 0 in parallel.
  - sel goes to 0.
  - Next state FETCH.
- State FETCH (HW_K+1 cycles):
  - sel increments each cycle from 0 to HW_K-1, then holds.
  - data_in for rank r is sampled the cycle after sel==r, so sampling is pipelined one cycle behind sel.
  - For each sampled label L < N_CLASSES: count[L] += 1.
    - If the new count > best_count, best_label = L and best_count = the new count.
    - Comparison is strict, so a tie goes to the label that reached the tied count first.
  - For a label L >= N_CLASSES: no count is updated and err is set.
  - After the HW_K-th sample → OUT.
- State OUT:
  - res_valid=1, with res_label=best_label, res_votes=best_count (zero-extended) and res_solver=solver_sel.
  - All four outputs are held stable until res_valid && res_ready.
  - On acceptance:
    - If solver_sel == N_SOLVERS-1: res_valid=0, done=1 for one cycle, state goes to IDLE, solver_sel goes to 0.
    - Otherwise: solver_sel increments, res_valid=0, state goes to CLEAR.
  - res_ready asserted while res_valid==0 has no effect.
- If all HW_K labels are out of range: res_label=0, res_votes=0, err=1.
- Latency per solver with res_ready held high: 1 (CLEAR) + HW_K+1 (FETCH) + 1 (OUT) = HW_K+3 cycles.
  - The first res_valid appears HW_K+3 cycles after the start edge.
- busy: 1 in CLEAR/FETCH/OUT, 0 in IDLE; it falls in the same cycle done pulses.
- Width rules: sel and solver_sel are zero-extended to 16 bits. Counters cannot overflow, since the maximum count is HW_K.

Test Plan:
- Reset and idle:
  - Hold rst=0 for 3 cycles, then release → every output is 0.
  - Pulse start → busy=1 next cycle, sel steps 0..9.
- Clear majority (HW_K=10, N_SOLVERS=1):
  - knn model returns labels {3,3,5,3,7,3,5,3,1,3} → res_label=3, res_votes=6, res_solver=0.
  - res_valid rises 13 cycles after start; done pulses after acceptance.
- Tie-break:
  - Labels {4,2,4,2,9,9,9,2,4,0} → 4, 2 and 9 each reach 3.
  - 9 reaches 3 first, at rank 6 → res_label=9, res_votes=3.
- Backpressure and multi-solver (N_SOLVERS=3):
  - Solver c returns all labels = c+1; res_ready held low for 5 cycles each time res_valid rises.
  - → results (label 1, votes 10, solver 0), (2, 10, 1), (3, 10, 2).
  - Outputs stable while stalled; exactly one done pulse.
- Out-of-range labels:
  - Labels {20,20,2,20,20,20,20,20,20,20} with N_CLASSES=16 → res_label=2, res_votes=1, err=1.
  - err clears on the next start.
- Reset mid-scan:
  - Assert rst=0 during FETCH at sel=4 → next cycle state is IDLE with all outputs 0.
  - No res_valid and no done; a following start runs a clean scan with correct results.

Source files
------------

// File: rtl/knn_vote.sv
// Majority-vote readout for the knn solver array: scans every solver's ranked
// neighbour list through sel/solver_sel and emits one winning label per solver.
module knn_vote #(
    parameter int HW_K      = 10,
    parameter int N_SOLVERS = 10,
    parameter int N_CLASSES = 16,
    parameter int LABEL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [15:0]        sel,
    output logic [15:0]        solver_sel,
    input  logic [LABEL_W-1:0] data_in,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [LABEL_W-1:0] res_label,
    output logic [15:0]        res_votes,
    output logic [15:0]        res_solver,
    output logic               done,
    output logic               err
);

    localparam int CNT_W = $clog2(HW_K + 1);
    localparam int CLS_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, FETCH, OUT} state_t;

    state_t                          state_q, state_d;
    logic [15:0]                     sel_q, sel_d;
    logic [15:0]                     solver_q, solver_d;
    logic [CNT_W-1:0]                fetch_q, fetch_d;
    logic [LABEL_W-1:0]              lbl_q, lbl_d;
    logic                            lbl_vld_q, lbl_vld_d;
    logic [N_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CLS_W-1:0]                best_label_q, best_label_d;
    logic [CNT_W-1:0]                best_count_q, best_count_d;
    logic                            err_q, err_d;
    logic                            done_q, done_d;

    logic [CLS_W-1:0] lbl_idx;
    logic [CNT_W-1:0] new_count;
    logic             in_range;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        solver_d     = solver_q;
        fetch_d      = fetch_q;
        lbl_d        = lbl_q;
        lbl_vld_d    = 1'b0;
        cnt_d        = cnt_q;
        best_label_d = best_label_q;
        best_count_d = best_count_q;
        err_d        = err_q;
        done_d       = 1'b0;

        in_range  = lbl_q < LABEL_W'(N_CLASSES);
        lbl_idx   = lbl_q[CLS_W-1:0];
        new_count = cnt_q[lbl_idx] + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLEAR;
                    solver_d = '0;
                    err_d    = 1'b0;
                end
            end
            CLEAR: begin
                cnt_d        = '0;
                best_label_d = '0;
                best_count_d = '0;
                sel_d        = '0;
                fetch_d      = '0;
                state_d      = FETCH;
            end
            FETCH: begin
                if (sel_q < 16'(HW_K - 1))
                    sel_d = sel_q + 16'd1;
                // Label for the current rank is registered and voted next cycle.
                lbl_d     = data_in;
                lbl_vld_d = fetch_q < CNT_W'(HW_K);
                if (lbl_vld_q) begin
                    if (in_range) begin
                        cnt_d[lbl_idx] = new_count;
                        // Strict compare: earliest label to reach a tied count wins.
                        if (new_count > best_count_q) begin
                            best_label_d = lbl_idx;
                            best_count_d = new_count;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (fetch_q == CNT_W'(HW_K))
                    state_d = OUT;
                else
                    fetch_d = fetch_q + CNT_W'(1);
            end
            OUT: begin
                if (res_ready) begin
                    if (solver_q == 16'(N_SOLVERS - 1)) begin
                        done_d   = 1'b1;
                        state_d  = IDLE;
                        solver_d = '0;
                        sel_d    = '0;
                    end else begin
                        solver_d = solver_q + 16'd1;
                        state_d  = CLEAR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            solver_q     <= '0;
            fetch_q      <= '0;
            lbl_q        <= '0;
            lbl_vld_q    <= 1'b0;
            cnt_q        <= '0;
            best_label_q <= '0;
            best_count_q <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            solver_q     <= solver_d;
            fetch_q      <= fetch_d;
            lbl_q        <= lbl_d;
            lbl_vld_q    <= lbl_vld_d;
            cnt_q        <= cnt_d;
            best_label_q <= best_label_d;
            best_count_q <= best_count_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    assign sel        = sel_q;
    assign solver_sel = solver_q;
    assign busy       = state_q != IDLE;
    assign res_valid  = state_q == OUT;
    assign res_label  = res_valid ? LABEL_W'(best_label_q) : '0;
    assign res_votes  = res_valid ? 16'(best_count_q) : '0;
    assign res_solver = res_valid ? solver_q : '0;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote: three-solver knn label model, hand-computed vote results.
module tb_knn_vote;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] sel, solver_sel;
    logic [15:0] data_in;
    logic        busy, res_valid, res_ready;
    logic [15:0] res_label, res_votes, res_solver;
    logic        done, err;

    knn_vote #(.HW_K(10), .N_SOLVERS(3), .N_CLASSES(16), .LABEL_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .solver_sel(solver_sel),
        .data_in(data_in), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_label(res_label), .res_votes(res_votes), .res_solver(res_solver),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [15:0] tab [3][10];
    int exp_lbl [3];
    int exp_vot [3];
    int n_chk = 0, n_fail = 0, n_done = 0;

    always_comb begin
        data_in = 16'hffff;
        if (solver_sel < 16'd3 && sel < 16'd10)
            data_in = tab[solver_sel[1:0]][sel[3:0]];
    end

    always @(posedge clk) if (done) n_done++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed literal lists rank 0 first, i.e. at the top index.
    task automatic set_row(input int s, input logic [9:0][15:0] v, input int el, input int ev);
        for (int r = 0; r < 10; r++) tab[s][r] = v[9-r];
        exp_lbl[s] = el;
        exp_vot[s] = ev;
    endtask

    task automatic run_scan(input int stall, input logic exp_err);
        int cyc;
        int d0;
        d0 = n_done;
        res_ready = (stall == 0);
        start = 1'b1; step(); start = 1'b0;
        chk("busy_start", busy, 1);
        chk("err_clr_on_start", err, 0);
        for (int s = 0; s < 3; s++) begin
            cyc = 1;
            while (!res_valid && cyc < 40) begin
                step();
                cyc++;
                if (s == 0 && cyc <= 11) chk("sel_step", sel, cyc - 2);
            end
            chk("latency", cyc, 13);
            chk("res_valid", res_valid, 1);
            if (!res_valid) return;
            chk("res_label", res_label, exp_lbl[s]);
            chk("res_votes", res_votes, exp_vot[s]);
            chk("res_solver", res_solver, s);
            for (int i = 0; i < stall; i++) begin
                step();
                chk("hold_valid", res_valid, 1);
                chk("hold_label", res_label, exp_lbl[s]);
                chk("hold_votes", res_votes, exp_vot[s]);
                chk("hold_solver", res_solver, s);
            end
            res_ready = 1'b1; step(); res_ready = (stall == 0);
            chk("valid_drop", res_valid, 0);
            chk("done_at_accept", done, s == 2);
            chk("busy_at_accept", busy, s != 2);
        end
        step();
        chk("done_one_cycle", done, 0);
        chk("done_count", n_done - d0, 1);
        chk("err_end", err, exp_err);
        res_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b0; start = 1'b0; res_ready = 1'b0;
        for (int s = 0; s < 3; s++) set_row(s, '0, 0, 1);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rst_sel", sel, 0);
        chk("rst_solver_sel", solver_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_label", res_label, 0);
        chk("rst_votes", res_votes, 0);
        chk("rst_solver", res_solver, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // majority, tie-break, out-of-range; ready held high throughout
        set_row(0, {16'd3, 16'd3, 16'd5, 16'd3, 16'd7, 16'd3, 16'd5, 16'd3, 16'd1, 16'd3}, 3, 6);
        set_row(1, {16'd4, 16'd2, 16'd4, 16'd2, 16'd9, 16'd9, 16'd9, 16'd2, 16'd4, 16'd0}, 9, 3);
        set_row(2, {16'd20, 16'd20, 16'd2, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20}, 2, 1);
        run_scan(0, 1'b1);

        // backpressure, solver c votes unanimously for c+1
        for (int s = 0; s < 3; s++) set_row(s, {10{16'(s + 1)}}, s + 1, 10);
        run_scan(5, 1'b0);

        // all out of range, top label, all distinct
        set_row(0, {10{16'd16}}, 0, 0);
        set_row(1, {10{16'd15}}, 15, 10);
        set_row(2, {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9}, 0, 1);
        run_scan(0, 1'b1);

        // reset during FETCH at sel==4
        set_row(0, {16'd20, 16'd20, 16'd2, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20}, 2, 1);
        start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        while (!(busy && sel == 16'd4) && cnt < 20) begin step(); cnt++; end
        chk("reach_sel4", sel, 4);
        chk("err_pre_rst", err, 1);
        rst = 1'b0; step(); rst = 1'b1;
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_solver_sel", solver_sel, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (res_valid || done || busy) cnt++;
        end
        chk("no_activity_after_rst", cnt, 0);

        set_row(0, {16'd3, 16'd3, 16'd5, 16'd3, 16'd7, 16'd3, 16'd5, 16'd3, 16'd1, 16'd3}, 3, 6);
        set_row(1, {16'd4, 16'd2, 16'd4, 16'd2, 16'd9, 16'd9, 16'd9, 16'd2, 16'd4, 16'd0}, 9, 3);
        set_row(2, {10{16'd7}}, 7, 10);
        run_scan(0, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
